// File: rtl/final_adder_arbiter.sv
// Arbitrates NREQ reduction trees onto one shared carry-chain final adder, with an operand
// register stage feeding the adder and a result register stage. Define FINAL_ADDER_RR_EN for round-robin.
module final_adder_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 38,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_prop,
  input  logic [NREQ*W-1:0] req_gen,
  input  logic [NREQ-1:0]   req_cin,
  output logic              add_valid,
  output logic [W-1:0]      add_prop,
  output logic [W-1:0]      add_gen,
  output logic              add_cin,
  input  logic [W-1:0]      add_sum,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_sum,
  output logic [IDW-1:0]    out_id
);

  localparam logic [IDW:0] LP_NREQ = (IDW+1)'(NREQ);

  logic [W-1:0]   w_prop [NREQ];
  logic [W-1:0]   w_gen  [NREQ];
  logic [IDW-1:0] w_ptr;
  logic           w_out_load;
  logic           w_s1_free;
  logic           w_grant_any;
  logic [IDW-1:0] w_grant_id;
  logic           w_accept;

  logic           r_add_valid;
  logic [W-1:0]   r_add_prop;
  logic [W-1:0]   r_add_gen;
  logic           r_add_cin;
  logic [IDW-1:0] r_tag;
  logic           r_out_valid;
  logic [W-1:0]   r_out_sum;
  logic [IDW-1:0] r_out_id;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_prop[gi] = req_prop[gi*W +: W];
      assign w_gen[gi]  = req_gen[gi*W +: W];
    end
  endgenerate

`ifdef FINAL_ADDER_RR_EN
  logic [IDW-1:0] r_rr_ptr;
  logic [IDW:0]   w_ptr_inc;

  assign w_ptr     = r_rr_ptr;
  assign w_ptr_inc = {1'b0, w_grant_id} + (IDW+1)'(1);

  // Next search starts just above the requester that was served.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_accept) begin
      r_rr_ptr <= (w_ptr_inc == LP_NREQ) ? '0 : w_ptr_inc[IDW-1:0];
    end
  end
`else
  assign w_ptr = '0;
`endif

  assign w_out_load = r_add_valid & (~r_out_valid | out_ready);
  assign w_s1_free  = ~r_add_valid | w_out_load;

  always_comb begin : p_grant
    logic [IDW:0] w_idx;
    w_grant_any = 1'b0;
    w_grant_id  = '0;
    w_idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = {1'b0, w_ptr} + (IDW+1)'(k);
      if (w_idx >= LP_NREQ) begin
        w_idx = w_idx - LP_NREQ;
      end
      if (!w_grant_any && req_valid[w_idx[IDW-1:0]]) begin
        w_grant_any = 1'b1;
        w_grant_id  = w_idx[IDW-1:0];
      end
    end
  end

  assign w_accept = w_grant_any & w_s1_free & ~rst;

  always_comb begin
    req_ready = '0;
    if (w_accept) begin
      req_ready[w_grant_id] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_add_valid <= 1'b0;
      r_add_prop  <= '0;
      r_add_gen   <= '0;
      r_add_cin   <= 1'b0;
      r_tag       <= '0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_id    <= '0;
    end else begin
      if (w_accept) begin
        r_add_valid <= 1'b1;
        r_add_prop  <= w_prop[w_grant_id];
        r_add_gen   <= w_gen[w_grant_id];
        r_add_cin   <= req_cin[w_grant_id];
        r_tag       <= w_grant_id;
      end else if (w_out_load) begin
        r_add_valid <= 1'b0;
      end
      // Result stage captures the adder output; a popped result with nothing behind it empties.
      if (w_out_load) begin
        r_out_sum   <= add_sum;
        r_out_id    <= r_tag;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign add_valid = r_add_valid;
  assign add_prop  = r_add_prop;
  assign add_gen   = r_add_gen;
  assign add_cin   = r_add_cin;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_id    = r_out_id;

endmodule
